// File: rtl/mips_cpu_run_pkg.sv
// Shared types for the MIPS CPU run controller: FSM states and per-channel v0 slicing.
package mips_cpu_run_pkg;

  localparam int V0_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } run_state_e;

  function automatic int v0_lsb(input int ch);
    return ch * V0_W;
  endfunction

endpackage

// File: rtl/mips_cpu_run_channel.sv
// One monitored CPU: start check, sticky halt detection and delayed register_v0 capture.
module mips_cpu_run_channel
  import mips_cpu_run_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            check,
  input  logic            run_en,
  input  logic            active,
  input  logic [V0_W-1:0] v0,
  output logic            halted,
  output logic            pending,
  output logic            start_err,
  output logic [V0_W-1:0] result
);

  logic            halted_q, halted_d;
  logic            pending_q, pending_d;
  logic            start_err_q, start_err_d;
  logic [V0_W-1:0] result_q, result_d;

  always_comb begin
    halted_d    = halted_q;
    pending_d   = pending_q;
    start_err_d = start_err_q;
    result_d    = result_q;
    if (clear) begin
      halted_d    = 1'b0;
      pending_d   = 1'b0;
      start_err_d = 1'b0;
      result_d    = '0;
    end else if (run_en) begin
      // v0 writeback settles one cycle after active drops, so sample it then.
      if (pending_q) begin
        result_d  = v0;
        pending_d = 1'b0;
      end
      if (!halted_q && !active) begin
        halted_d = 1'b1;
        if (check) start_err_d = 1'b1;
        else       pending_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q    <= 1'b0;
      pending_q   <= 1'b0;
      start_err_q <= 1'b0;
      result_q    <= '0;
    end else begin
      halted_q    <= halted_d;
      pending_q   <= pending_d;
      start_err_q <= start_err_d;
      result_q    <= result_d;
    end
  end

  assign halted    = halted_q;
  assign pending   = pending_q;
  assign start_err = start_err_q;
  assign result    = result_q;

endmodule

// File: rtl/mips_cpu_run_controller.sv
// Run controller: resets the CPUs, runs them until all halt or a cycle budget expires,
// and reports captured register_v0 values with done/timeout status.
module mips_cpu_run_controller
  import mips_cpu_run_pkg::*;
#(
  parameter int N_CPU          = 1,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int RESET_CYCLES   = 1,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_CPU-1:0]        cpu_active,
  input  logic [V0_W*N_CPU-1:0]   cpu_register_v0,
  output logic                    cpu_reset,
  output logic                    cpu_clk_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [N_CPU-1:0]        start_err,
  output logic [N_CPU-1:0]        halted,
  output logic [V0_W*N_CPU-1:0]   result,
  output logic [CNT_W-1:0]        cycle_count
);

  run_state_e       state_q;
  logic [31:0]      rst_cnt_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             timeout_q, cpu_reset_q, clk_en_q, busy_q, done_q;

  logic             clear, check, run_en, all_halt_nxt, tmo_hit;
  logic [N_CPU-1:0] pending_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign clear  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign check  = (state_q == ST_RUN) && (cycle_count_q == '0);
  assign run_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // Exit decisions look at halted as it will be after this cycle.
  assign all_halt_nxt = &(halted | ~cpu_active);
  assign tmo_hit      = (64'(cycle_count_q) == 64'(TIMEOUT_CYCLES - 1));

  for (genvar i = 0; i < N_CPU; i++) begin : g_ch
    mips_cpu_run_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .check     (check),
      .run_en    (run_en),
      .active    (cpu_active[i]),
      .v0        (cpu_register_v0[v0_lsb(i) +: V0_W]),
      .halted    (halted[i]),
      .pending   (pending_unused[i]),
      .start_err (start_err[i]),
      .result    (result[v0_lsb(i) +: V0_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      cpu_reset_q   <= 1'b0;
      clk_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q       <= ST_RESET;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            cpu_reset_q   <= 1'b1;
            clk_en_q      <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
          end
        end
        ST_RESET: begin
          if (rst_cnt_q == 32'(RESET_CYCLES - 1)) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 32'd1;
          end
        end
        ST_RUN: begin
          // A final halt on the last budgeted cycle still counts as a clean finish.
          if (all_halt_nxt) begin
            state_q       <= ST_DRAIN;
            cycle_count_q <= sat_inc(cycle_count_q);
          end else if (tmo_hit) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cycle_count_q <= sat_inc(cycle_count_q);
          end
        end
        ST_DRAIN: begin
          state_q  <= ST_DONE;
          clk_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cpu_reset_q <= 1'b0;
          clk_en_q    <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset      = cpu_reset_q;
  assign cpu_clk_enable = clk_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign cycle_count    = cycle_count_q;

endmodule
